// File: rtl/interrupt_sequencer.sv
// Interrupt/reset entry sequencer: pushes PC and status, fetches the vector, loads PC.
// Ports: clk/rst, requests (res/nmi/irq), i_flag, instr_done, rdy, CPU state in, bus and PC control out.
module interrupt_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_req,
  input  logic        nmi_req,
  input  logic        irq_req,
  input  logic        i_flag,
  input  logic        instr_done,
  input  logic        rdy,
  input  logic [15:0] pc_in,
  input  logic [7:0]  p_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  data_in,
  output logic        seq_active,
  output logic [15:0] addr_out,
  output logic [7:0]  data_out,
  output logic        rw,
  output logic        sp_dec,
  output logic        pc_load,
  output logic [15:0] pc_load_val,
  output logic        set_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_RES_HOLD, S_PUSH_PCH, S_PUSH_PCL,
    S_PUSH_P, S_FETCH_VL, S_FETCH_VH, S_LOAD
  } state_t;

  typedef enum logic [1:0] {
    K_RES = 2'd0,
    K_NMI = 2'd1,
    K_IRQ = 2'd2
  } kind_t;

  state_t     state, state_nx;
  kind_t      kind, kind_nx;
  logic       nmi_pend, pend_nx;
  logic [7:0] sp_base, sp_nx;
  logic [7:0] vl, vl_nx, vh, vh_nx;
  logic [7:0] sp_m1, sp_m2;
  logic [15:0] vec;
  logic       go, wr, nmi_any;

  // Abort and stall both freeze sequencing side effects.
  assign go      = rdy & ~res_req;
  assign wr      = (kind != K_RES);
  assign nmi_any = nmi_pend | nmi_req;
  assign sp_m1   = sp_base - 8'd1;
  assign sp_m2   = sp_base - 8'd2;
  assign pc_load_val = {vh, vl};

  always_comb begin
    unique case (kind)
      K_NMI:   vec = 16'hFFFA;
      K_IRQ:   vec = 16'hFFFE;
      default: vec = 16'hFFFC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RES_HOLD;
      kind     <= K_RES;
      nmi_pend <= 1'b0;
      sp_base  <= 8'h00;
      vl       <= 8'h00;
      vh       <= 8'h00;
    end else begin
      state    <= state_nx;
      kind     <= kind_nx;
      nmi_pend <= pend_nx;
      sp_base  <= sp_nx;
      vl       <= vl_nx;
      vh       <= vh_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    kind_nx    = kind;
    pend_nx    = nmi_any;
    sp_nx      = sp_base;
    vl_nx      = vl;
    vh_nx      = vh;
    seq_active = 1'b1;
    addr_out   = 16'h0000;
    data_out   = 8'h00;
    rw         = 1'b0;
    sp_dec     = 1'b0;
    pc_load    = 1'b0;
    set_i      = 1'b0;
    unique case (state)
      S_IDLE: begin
        seq_active = 1'b0;
        if (go && instr_done) begin
          if (nmi_pend) begin
            state_nx = S_PUSH_PCH;
            kind_nx  = K_NMI;
            sp_nx    = sp_in;
          end else if (irq_req && !i_flag) begin
            state_nx = S_PUSH_PCH;
            kind_nx  = K_IRQ;
            sp_nx    = sp_in;
          end
        end
      end
      S_RES_HOLD: begin
        addr_out = pc_in;
        if (go) begin
          state_nx = S_PUSH_PCH;
          kind_nx  = K_RES;
          sp_nx    = sp_in;
        end
      end
      S_PUSH_PCH: begin
        addr_out = {8'h01, sp_base};
        data_out = pc_in[15:8];
        rw       = wr & go;
        sp_dec   = go;
        if (go) state_nx = S_PUSH_PCL;
      end
      S_PUSH_PCL: begin
        addr_out = {8'h01, sp_m1};
        data_out = pc_in[7:0];
        rw       = wr & go;
        sp_dec   = go;
        if (go) state_nx = S_PUSH_P;
      end
      S_PUSH_P: begin
        addr_out = {8'h01, sp_m2};
        // Pushed status has B clear and bit 5 set.
        data_out = (p_in | 8'h20) & 8'hEF;
        rw       = wr & go;
        sp_dec   = go;
        if (go) begin
          state_nx = S_FETCH_VL;
          // A late NMI steals a running IRQ sequence.
          if (kind == K_IRQ && nmi_any) kind_nx = K_NMI;
          if (kind_nx == K_NMI) pend_nx = 1'b0;
        end
      end
      S_FETCH_VL: begin
        addr_out = vec;
        if (go) begin
          vl_nx    = data_in;
          state_nx = S_FETCH_VH;
        end
      end
      S_FETCH_VH: begin
        addr_out = vec | 16'h0001;
        if (go) begin
          vh_nx    = data_in;
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        pc_load = go;
        set_i   = go;
        if (go) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (res_req) state_nx = S_RES_HOLD;
  end

endmodule
